mc_bus_if: RTL and testbench

- Front-end slave for the MCU parallel memory-controller bus (mc_ce/mc_we/mc_oe/mc_add/mc_data) feeding the FPGA register file: IO pin control, SRAM/LA control, LA sample count, PWM.
- Synchronises the asynchronous MCU strobes into the clock domain.
- Buffers register writes in a small FIFO toward the register file.
- Serves reads in order behind pending writes, and drives read data back onto the bus.

---
 rtl/mc_bus_if_pkg.sv | 18 +
 rtl/mc_bus_if_if.sv | 49 ++++
 rtl/mc_bus_if_wr_fifo.sv | 59 +++++
 rtl/mc_bus_if.sv | 148 ++++++++++++++
 tb/tb_mc_bus_if.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_bus_if_pkg.sv
// Shared definitions for the MCU memory-controller bus front end:
// default bus widths, read FSM states and the read-timeout filler word.
package bp_mc_pkg;

    localparam int MC_DATA_WIDTH_DEF = 16;
    localparam int MC_ADD_WIDTH_DEF  = 6;

    localparam logic [15:0] RD_FILL = 16'hDEAD;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        REQ,
        WAIT,
        HOLD
    } rd_state_e;

endpackage

// File: rtl/mc_bus_if_if.sv
// Bus bundle between the MCU pins, the front end and the register file.
// slave = front-end view, master = MCU/register-file (environment) view.
interface mc_bus_if_if
    import bp_mc_pkg::*;
#(
    parameter int MC_DATA_WIDTH = MC_DATA_WIDTH_DEF,
    parameter int MC_ADD_WIDTH  = MC_ADD_WIDTH_DEF
);
    logic                     mc_ce;
    logic                     mc_we;
    logic                     mc_oe;
    logic [MC_ADD_WIDTH-1:0]  mc_add;
    logic [MC_DATA_WIDTH-1:0] mc_data_in;
    logic [MC_DATA_WIDTH-1:0] mc_data_out;
    logic                     mc_data_oe;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [MC_ADD_WIDTH-1:0]  wr_addr;
    logic [MC_DATA_WIDTH-1:0] wr_data;
    logic                     rd_req;
    logic [MC_ADD_WIDTH-1:0]  rd_addr;
    logic [MC_DATA_WIDTH-1:0] rd_data;
    logic                     rd_valid;
    logic                     wr_overflow;
    logic                     ovf_clr;

    modport slave (
        input  mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
        output mc_data_out, mc_data_oe,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd_req, rd_addr,
        input  rd_data, rd_valid,
        output wr_overflow,
        input  ovf_clr
    );

    modport master (
        output mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
        input  mc_data_out, mc_data_oe,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd_req, rd_addr,
        output rd_data, rd_valid,
        input  wr_overflow,
        output ovf_clr
    );

endinterface

// File: rtl/mc_bus_if_wr_fifo.sv
// First-word-fall-through FIFO of {addr,data} register writes.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module mc_wr_fifo #(
    parameter int AW    = 6,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [AW-1:0]              addr_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       pop_i,
    output logic [AW-1:0]              addr_o,
    output logic [DW-1:0]              data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign count_o = cnt_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign {addr_o, data_o} = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= {addr_i, data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mc_bus_if.sv
// MCU parallel-bus slave: strobe synchronisers, buffered writes and in-order reads.
// Define MC_RD_TIMEOUT_EN to return 16'hDEAD when the register file never answers.
module mc_bus_if
    import bp_mc_pkg::*;
#(
    parameter int MC_DATA_WIDTH = MC_DATA_WIDTH_DEF,
    parameter int MC_ADD_WIDTH  = MC_ADD_WIDTH_DEF,
    parameter int FIFO_DEPTH    = 4,
    parameter int RD_TIMEOUT    = 15
) (
    input  logic          clock,
    input  logic          reset,
    mc_bus_if_if.slave    bus
);
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (RD_TIMEOUT < 2)) begin : g_bad_cfg
        $error("mc_bus_if: FIFO_DEPTH must be a power of two >= 2 and RD_TIMEOUT >= 2");
    end

    logic ce_s1_q, ce_s2_q;
    logic we_s1_q, we_s2_q, we_h_q;
    logic oe_s1_q, oe_s2_q, oe_h_q;

    rd_state_e                state_q, state_d;
    logic [MC_ADD_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [MC_DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                     ovf_q, ovf_d;

    logic                     fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic                     wr_accept, wr_drop, rd_start;

    assign wr_accept = we_h_q && !we_s2_q && !ce_s2_q;
    assign rd_start  = oe_h_q && !oe_s2_q && !ce_s2_q;
    assign fifo_pop  = !fifo_empty && bus.wr_ready;
    assign wr_drop   = wr_accept && fifo_full && !fifo_pop;
    assign ovf_d     = wr_drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);

    mc_wr_fifo #(
        .AW    (MC_ADD_WIDTH),
        .DW    (MC_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (wr_accept),
        .addr_i  (bus.mc_add),
        .data_i  (bus.mc_data_in),
        .pop_i   (fifo_pop),
        .addr_o  (bus.wr_addr),
        .data_o  (bus.wr_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus.wr_valid    = !fifo_empty;
    assign bus.wr_overflow = ovf_q;
    assign bus.rd_req      = (state_q == REQ);
    assign bus.rd_addr     = rd_addr_q;
    assign bus.mc_data_out = data_out_q;
    assign bus.mc_data_oe  = !oe_s2_q && !ce_s2_q;

`ifdef MC_RD_TIMEOUT_EN
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_expired;

    // Counts clocks since the rd_req cycle, so expiry lands RD_TIMEOUT clocks after it.
    assign tmo_d       = ((state_q == REQ) || (state_q == WAIT)) ? tmo_q + TW'(1) : '0;
    assign tmo_expired = (tmo_q == TW'(RD_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    rd_addr_d = bus.mc_add;
                    // A write accepted this same cycle must land before the read.
                    state_d   = (!fifo_empty || wr_accept) ? DRAIN : REQ;
                end
            end
            DRAIN: begin
                if (oe_s2_q)              state_d = IDLE;
                else if (fifo_cnt == '0)  state_d = REQ;
            end
            REQ: begin
                state_d = oe_s2_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (oe_s2_q) begin
                    state_d = IDLE;
                end else if (bus.rd_valid) begin
                    data_out_d = bus.rd_data;
                    state_d    = HOLD;
                end
`ifdef MC_RD_TIMEOUT_EN
                else if (tmo_expired) begin
                    data_out_d = MC_DATA_WIDTH'(RD_FILL);
                    state_d    = HOLD;
                end
`endif
            end
            HOLD: begin
                if (oe_s2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ce_s1_q    <= 1'b1;
            ce_s2_q    <= 1'b1;
            we_s1_q    <= 1'b1;
            we_s2_q    <= 1'b1;
            we_h_q     <= 1'b1;
            oe_s1_q    <= 1'b1;
            oe_s2_q    <= 1'b1;
            oe_h_q     <= 1'b1;
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ce_s1_q    <= bus.mc_ce;
            ce_s2_q    <= ce_s1_q;
            we_s1_q    <= bus.mc_we;
            we_s2_q    <= we_s1_q;
            we_h_q     <= we_s2_q;
            oe_s1_q    <= bus.mc_oe;
            oe_s2_q    <= oe_s1_q;
            oe_h_q     <= oe_s2_q;
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mc_bus_if.sv
// Directed bench for mc_bus_if: table-driven writes and reads plus
// hand-written FIFO-full, coherence, abort, reset and timeout sequences.
module tb_mc_bus_if;

    logic clock;
    logic reset;
    int   errs;
    int   checks;

    mc_bus_if_if #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6)) bus ();

    mc_bus_if #(
        .MC_DATA_WIDTH (16),
        .MC_ADD_WIDTH  (6),
        .FIFO_DEPTH    (4),
        .RD_TIMEOUT    (15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  add;
        logic [15:0] data;
        logic [5:0]  exp_addr;
        logic [15:0] exp_data;
    } wr_vec_t;

    typedef struct {
        logic [5:0]  add;
        logic [15:0] rdata;
        logic [5:0]  exp_rd_addr;
        logic [15:0] exp_out;
    } rd_vec_t;

    wr_vec_t wv[4];
    rd_vec_t rv[3];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_rd_req(input string nm, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (bus.rd_req === 1'b1) break;
            tick();
        end
        chk(nm, 32'(bus.rd_req), 32'd1);
    endtask

    task automatic mcu_write(input logic [5:0] a, input logic [15:0] d);
        bus.mc_add     = a;
        bus.mc_data_in = d;
        bus.mc_ce      = 1'b0;
        tick();
        bus.mc_we = 1'b0;
        ticks(6);
        bus.mc_we = 1'b1;
        ticks(2);
        bus.mc_ce = 1'b1;
        ticks(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;
        errs   = 0;
        checks = 0;

        wv[0] = '{add: 6'h03, data: 16'h001B, exp_addr: 6'h03, exp_data: 16'h001B};
        wv[1] = '{add: 6'h3F, data: 16'hFFFF, exp_addr: 6'h3F, exp_data: 16'hFFFF};
        wv[2] = '{add: 6'h00, data: 16'h0000, exp_addr: 6'h00, exp_data: 16'h0000};
        wv[3] = '{add: 6'h2A, data: 16'hA5A5, exp_addr: 6'h2A, exp_data: 16'hA5A5};

        rv[0] = '{add: 6'h09, rdata: 16'h4321, exp_rd_addr: 6'h09, exp_out: 16'h4321};
        rv[1] = '{add: 6'h3F, rdata: 16'hFFFF, exp_rd_addr: 6'h3F, exp_out: 16'hFFFF};
        rv[2] = '{add: 6'h00, rdata: 16'h5A5A, exp_rd_addr: 6'h00, exp_out: 16'h5A5A};

        reset          = 1'b0;
        bus.mc_ce      = 1'b1;
        bus.mc_we      = 1'b1;
        bus.mc_oe      = 1'b1;
        bus.mc_add     = '0;
        bus.mc_data_in = '0;
        bus.wr_ready   = 1'b0;
        bus.rd_data    = '0;
        bus.rd_valid   = 1'b0;
        bus.ovf_clr    = 1'b0;

        ticks(3);
        chk("rst_data_out", 32'(bus.mc_data_out), 32'h0);
        chk("rst_data_oe",  32'(bus.mc_data_oe),  32'h0);
        chk("rst_wr_valid", 32'(bus.wr_valid),    32'h0);
        chk("rst_rd_req",   32'(bus.rd_req),      32'h0);
        chk("rst_rd_addr",  32'(bus.rd_addr),     32'h0);
        chk("rst_ovf",      32'(bus.wr_overflow), 32'h0);
        reset = 1'b1;
        ticks(2);

        // Write path: entry appears 3 clocks after we falls and is popped once.
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mc_add     = wv[i].add;
            bus.mc_data_in = wv[i].data;
            bus.mc_ce      = 1'b0;
            bus.mc_we      = 1'b0;
            ticks(2);
            chk($sformatf("wp%0d_early", i), 32'(bus.wr_valid), 32'h0);
            tick();
            chk($sformatf("wp%0d_valid", i), 32'(bus.wr_valid), 32'h1);
            chk($sformatf("wp%0d_addr", i),  32'(bus.wr_addr),  32'(wv[i].exp_addr));
            chk($sformatf("wp%0d_data", i),  32'(bus.wr_data),  32'(wv[i].exp_data));
            tick();
            chk($sformatf("wp%0d_popped", i), 32'(bus.wr_valid), 32'h0);
            ticks(3);
            bus.mc_we = 1'b1;
            ticks(2);
            bus.mc_ce = 1'b1;
            ticks(4);
            chk($sformatf("wp%0d_single", i), 32'(bus.wr_valid), 32'h0);
        end
        chk("wp_no_ovf", 32'(bus.wr_overflow), 32'h0);

        // FIFO full: four kept in order, fifth dropped, sticky overflow.
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mcu_write(6'(i), 16'h0100 + 16'(i));
            if (i == 3) chk("full_no_ovf_yet", 32'(bus.wr_overflow), 32'h0);
        end
        chk("full_ovf_set", 32'(bus.wr_overflow), 32'h1);
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full_head%0d_addr", i), 32'(bus.wr_addr), 32'(i));
            chk($sformatf("full_head%0d_data", i), 32'(bus.wr_data), 32'h0100 + 32'(i));
            tick();
        end
        chk("full_drained", 32'(bus.wr_valid), 32'h0);
        ticks(3);
        chk("ovf_sticky", 32'(bus.wr_overflow), 32'h1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.wr_overflow), 32'h0);

        // Read-after-write: read waits for the pending write to drain.
        bus.wr_ready = 1'b0;
        mcu_write(6'h05, 16'h0001);
        bus.mc_add = 6'h05;
        bus.mc_ce  = 1'b0;
        bus.mc_oe  = 1'b0;
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rd_req === 1'b1) n_req++;
        end
        chk("raw_no_early_req", 32'(n_req), 32'h0);
        chk("raw_pending", 32'(bus.wr_valid), 32'h1);
        bus.wr_ready = 1'b1;
        wait_rd_req("raw_req", 6);
        chk("raw_fifo_empty", 32'(bus.wr_valid), 32'h0);
        chk("raw_rd_addr", 32'(bus.rd_addr), 32'h05);
        tick();
        chk("raw_req_one_cycle", 32'(bus.rd_req), 32'h0);
        bus.rd_data  = 16'h0001;
        bus.rd_valid = 1'b1;
        tick();
        bus.rd_valid = 1'b0;
        chk("raw_data_out", 32'(bus.mc_data_out), 32'h0001);
        chk("raw_data_oe",  32'(bus.mc_data_oe),  32'h1);
        bus.mc_oe = 1'b1;
        bus.mc_ce = 1'b1;
        ticks(4);
        chk("raw_oe_released", 32'(bus.mc_data_oe), 32'h0);

        // Read abort: late rd_valid must not update mc_data_out.
        bus.mc_add = 6'h07;
        bus.mc_ce  = 1'b0;
        bus.mc_oe  = 1'b0;
        wait_rd_req("abort_req", 10);
        tick();
        bus.mc_oe = 1'b1;
        ticks(5);
        bus.rd_data  = 16'h1234;
        bus.rd_valid = 1'b1;
        tick();
        bus.rd_valid = 1'b0;
        chk("abort_data_kept", 32'(bus.mc_data_out), 32'h0001);
        chk("abort_oe_low",    32'(bus.mc_data_oe),  32'h0);
        bus.mc_ce = 1'b1;
        ticks(3);

        // Table of plain reads; the first also proves the FSM is back in IDLE.
        for (int i = 0; i < 3; i++) begin
            bus.mc_add = rv[i].add;
            bus.mc_ce  = 1'b0;
            bus.mc_oe  = 1'b0;
            wait_rd_req($sformatf("rd%0d_req", i), 10);
            chk($sformatf("rd%0d_addr", i), 32'(bus.rd_addr), 32'(rv[i].exp_rd_addr));
            tick();
            bus.rd_data  = rv[i].rdata;
            bus.rd_valid = 1'b1;
            tick();
            bus.rd_valid = 1'b0;
            chk($sformatf("rd%0d_out", i), 32'(bus.mc_data_out), 32'(rv[i].exp_out));
            chk($sformatf("rd%0d_oe", i),  32'(bus.mc_data_oe),  32'h1);
            bus.mc_oe = 1'b1;
            bus.mc_ce = 1'b1;
            ticks(4);
        end

        // Simultaneous we and oe falls: write first, read drains behind it.
        bus.wr_ready   = 1'b0;
        bus.mc_add     = 6'h0A;
        bus.mc_data_in = 16'h00AA;
        bus.mc_ce      = 1'b0;
        bus.mc_we      = 1'b0;
        bus.mc_oe      = 1'b0;
        n_req = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.rd_req === 1'b1) n_req++;
        end
        chk("sim_no_req", 32'(n_req), 32'h0);
        chk("sim_wr_valid", 32'(bus.wr_valid), 32'h1);
        chk("sim_wr_addr",  32'(bus.wr_addr),  32'h0A);
        chk("sim_wr_data",  32'(bus.wr_data),  32'h00AA);
        bus.wr_ready = 1'b1;
        wait_rd_req("sim_req", 6);
        chk("sim_rd_addr", 32'(bus.rd_addr), 32'h0A);
        chk("sim_drained", 32'(bus.wr_valid), 32'h0);
        tick();
        bus.rd_data  = 16'h0BBB;
        bus.rd_valid = 1'b1;
        tick();
        bus.rd_valid = 1'b0;
        chk("sim_out", 32'(bus.mc_data_out), 32'h0BBB);
        bus.mc_we = 1'b1;
        bus.mc_oe = 1'b1;
        bus.mc_ce = 1'b1;
        ticks(4);

        // Register file never answers: timeout filler, or indefinite wait.
        bus.mc_add = 6'h15;
        bus.mc_ce  = 1'b0;
        bus.mc_oe  = 1'b0;
        wait_rd_req("tmo_req", 10);
        ticks(14);
        chk("tmo_before", 32'(bus.mc_data_out), 32'h0BBB);
        tick();
`ifdef MC_RD_TIMEOUT_EN
        chk("tmo_filler", 32'(bus.mc_data_out), 32'hDEAD);
`else
        chk("tmo_still_waiting", 32'(bus.mc_data_out), 32'h0BBB);
`endif
        bus.mc_oe = 1'b1;
        bus.mc_ce = 1'b1;
        ticks(4);

        // Reset in WAIT with two buffered writes.
        bus.rd_data  = 16'h0BBB;
        bus.rd_valid = 1'b1;
        bus.mc_add   = 6'h0C;
        bus.mc_ce    = 1'b0;
        bus.mc_oe    = 1'b0;
        tick();
        bus.rd_valid = 1'b0;
        wait_rd_req("rst_wait_req", 10);
        chk("rst_wait_rd_addr", 32'(bus.rd_addr), 32'h0C);
        tick();
        bus.wr_ready = 1'b0;
        bus.mc_add     = 6'h20;
        bus.mc_data_in = 16'h1111;
        bus.mc_we      = 1'b0;
        ticks(4);
        bus.mc_we = 1'b1;
        ticks(2);
        bus.mc_add     = 6'h21;
        bus.mc_data_in = 16'h2222;
        bus.mc_we      = 1'b0;
        ticks(4);
        bus.mc_we = 1'b1;
        ticks(2);
        chk("rst_pre_wr_valid", 32'(bus.wr_valid), 32'h1);
        chk("rst_pre_wr_addr",  32'(bus.wr_addr),  32'h20);
        chk("rst_pre_rd_addr",  32'(bus.rd_addr),  32'h0C);
        chk("rst_pre_oe",       32'(bus.mc_data_oe), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_data_out", 32'(bus.mc_data_out), 32'h0);
        chk("arst_data_oe",  32'(bus.mc_data_oe),  32'h0);
        chk("arst_wr_valid", 32'(bus.wr_valid),    32'h0);
        chk("arst_rd_req",   32'(bus.rd_req),      32'h0);
        chk("arst_rd_addr",  32'(bus.rd_addr),     32'h0);
        chk("arst_ovf",      32'(bus.wr_overflow), 32'h0);
        bus.mc_oe = 1'b1;
        bus.mc_ce = 1'b1;
        tick();
        reset = 1'b1;
        ticks(3);
        chk("post_rst_empty", 32'(bus.wr_valid), 32'h0);
        chk("post_rst_oe",    32'(bus.mc_data_oe), 32'h0);
        mcu_write(6'h11, 16'h2222);
        chk("post_rst_valid", 32'(bus.wr_valid), 32'h1);
        chk("post_rst_addr",  32'(bus.wr_addr),  32'h11);
        chk("post_rst_data",  32'(bus.wr_data),  32'h2222);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
